// File: rtl/ahb_aes_cfg_regs.sv
// ahb_aes_cfg_regs: AHB-Lite register bank for the AES accelerator.
// Holds the source/destination pointers, transfer size, mode, and key. It also
// generates the start pulse and keeps a sticky W1C status.
// Optional build macro: AES_CFG_IRQ_EN adds the IRQ_EN register at 0x14 and an irq output.
module ahb_aes_cfg_regs #(
    parameter int ADDR_W = 12,
    parameter int KEY_W  = 128,
    parameter int SIZE_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic              hready,
    input  logic [31:0]       hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [31:0]       hrdata,
    output logic [31:0]       src_addr,
    output logic [31:0]       dst_addr,
    output logic [SIZE_W-1:0] size_data,
    output logic [1:0]        mode,
    output logic [KEY_W-1:0]  key,
    output logic              start,
    input  logic              busy_in,
    input  logic              done_in
`ifdef AES_CFG_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int KEY_WORDS = KEY_W / 32;
    localparam int WIDX_W    = ADDR_W - 2;

    localparam logic [WIDX_W-1:0] W_SRC   = WIDX_W'(0);
    localparam logic [WIDX_W-1:0] W_DST   = WIDX_W'(1);
    localparam logic [WIDX_W-1:0] W_SIZE  = WIDX_W'(2);
    localparam logic [WIDX_W-1:0] W_CTRL  = WIDX_W'(3);
    localparam logic [WIDX_W-1:0] W_STAT  = WIDX_W'(4);
`ifdef AES_CFG_IRQ_EN
    localparam logic [WIDX_W-1:0] W_IRQEN = WIDX_W'(5);
`endif
    localparam logic [WIDX_W-1:0] W_KEY0  = WIDX_W'(8);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t            state_q, state_d;
    logic [WIDX_W-1:0] widx_a;
    logic [WIDX_W-1:0] widx_p1;
    logic              write_p1;
    logic              accept;
    logic              wr_en, rd_en;
    logic              cfg_target;
    logic              busy_drop;
    logic              ctrl_wr_ok;
    logic              start_go, start_err;
    logic              stat_wr;
    logic              done_q, cfg_err_q;
    logic [31:0]       key_q [KEY_WORDS];
    logic [31:0]       rd_word;
`ifdef AES_CFG_IRQ_EN
    logic [1:0]        irq_en_q;
`endif
    logic              unused_bits;

    // Word decode for the register map; true when the word has a register behind it.
    function automatic logic is_mapped(input logic [WIDX_W-1:0] w);
        logic hit;
        hit = (w <= W_STAT);
`ifdef AES_CFG_IRQ_EN
        if (w == W_IRQEN) hit = 1'b1;
`endif
        if (w >= W_KEY0 && w < W_KEY0 + WIDX_W'(KEY_WORDS)) hit = 1'b1;
        return hit;
    endfunction

    // Words that configure the core and are therefore locked while it is busy.
    function automatic logic is_cfg(input logic [WIDX_W-1:0] w);
        logic hit;
        hit = (w <= W_CTRL);
        if (w >= W_KEY0 && w < W_KEY0 + WIDX_W'(KEY_WORDS)) hit = 1'b1;
        return hit;
    endfunction

    assign unused_bits = ^{htrans[0], haddr[1:0]};
    assign widx_a      = haddr[ADDR_W-1:2];
    assign accept      = hsel & htrans[1] & hready;

    // FSM state register.
    always_ff @(posedge hclk) begin
        if (hreset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and response outputs; only ERR1 stalls the bus.
    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state_q)
            S_IDLE, S_DATA: begin
                if (accept) state_d = is_mapped(widx_a) ? S_DATA : S_ERR1;
                else        state_d = S_IDLE;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address-phase capture for the following data phase.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            widx_p1  <= '0;
            write_p1 <= 1'b0;
        end else if ((state_q == S_IDLE || state_q == S_DATA) && accept) begin
            widx_p1  <= widx_a;
            write_p1 <= hwrite;
        end
    end

    assign wr_en      = (state_q == S_DATA) && write_p1;
    assign rd_en      = (state_q == S_DATA) && !write_p1;
    assign cfg_target = is_cfg(widx_p1);
    assign busy_drop  = wr_en && cfg_target && busy_in;
    assign ctrl_wr_ok = wr_en && !busy_in && (widx_p1 == W_CTRL);
    assign start_go   = ctrl_wr_ok && hwdata[2] && (size_data != '0);
    assign start_err  = ctrl_wr_ok && hwdata[2] && (size_data == '0);
    assign stat_wr    = wr_en && (widx_p1 == W_STAT);

    // Register writes at the end of the data phase, start pulse and sticky status.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            src_addr  <= '0;
            dst_addr  <= '0;
            size_data <= '0;
            mode      <= '0;
            start     <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
`ifdef AES_CFG_IRQ_EN
            irq_en_q  <= '0;
`endif
        end else begin
            start <= start_go;
            if (wr_en && !busy_in) begin
                case (widx_p1)
                    W_SRC:   src_addr  <= hwdata;
                    W_DST:   dst_addr  <= hwdata;
                    W_SIZE:  size_data <= hwdata[SIZE_W-1:0];
                    W_CTRL:  mode      <= hwdata[1:0];
                    default: ;
                endcase
                for (int i = 0; i < KEY_WORDS; i++) begin
                    if (widx_p1 == W_KEY0 + WIDX_W'(i)) key_q[i] <= hwdata;
                end
            end
`ifdef AES_CFG_IRQ_EN
            if (wr_en && widx_p1 == W_IRQEN) irq_en_q <= hwdata[1:0];
`endif
            done_q    <= done_in | (done_q & ~(stat_wr & hwdata[1]));
            cfg_err_q <= busy_drop | start_err | (cfg_err_q & ~(stat_wr & hwdata[2]));
        end
    end

    // Key words map MSW-first onto the flat key output.
    for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
        assign key[KEY_W-1-32*g -: 32] = key_q[g];
    end

    // Read mux from the captured address; bus data is zero outside a read data phase.
    always_comb begin
        rd_word = '0;
        case (widx_p1)
            W_SRC:   rd_word = src_addr;
            W_DST:   rd_word = dst_addr;
            W_SIZE:  rd_word = 32'(size_data);
            W_CTRL:  rd_word = {30'b0, mode};
            W_STAT:  rd_word = {29'b0, cfg_err_q, done_q, busy_in};
`ifdef AES_CFG_IRQ_EN
            W_IRQEN: rd_word = {30'b0, irq_en_q};
`endif
            default: ;
        endcase
        for (int i = 0; i < KEY_WORDS; i++) begin
            if (widx_p1 == W_KEY0 + WIDX_W'(i)) rd_word = key_q[i];
        end
        hrdata = rd_en ? rd_word : 32'h0;
    end

`ifdef AES_CFG_IRQ_EN
    // Registered interrupt from enabled sticky status bits.
    always_ff @(posedge hclk) begin
        if (hreset) irq <= 1'b0;
        else        irq <= |({cfg_err_q, done_q} & irq_en_q);
    end
`endif

endmodule

// File: tb/tb_ahb_aes_cfg_regs.sv
// Directed testbench for ahb_aes_cfg_regs built with KEY_W=256.
// Covers AES_CFG_IRQ_EN when the macro is defined for the build.
module tb_ahb_aes_cfg_regs;

    localparam int ADDR_W = 12;
    localparam int KEY_W  = 256;
    localparam int SIZE_W = 32;

    logic              hclk = 1'b0;
    logic              hreset;
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic              hready;
    logic [31:0]       hwdata;
    logic              hreadyout;
    logic              hresp;
    logic [31:0]       hrdata;
    logic [31:0]       src_addr;
    logic [31:0]       dst_addr;
    logic [SIZE_W-1:0] size_data;
    logic [1:0]        mode;
    logic [KEY_W-1:0]  key;
    logic              start;
    logic              busy_in;
    logic              done_in;
`ifdef AES_CFG_IRQ_EN
    logic              irq;
`endif

    int tests = 0;
    int fails = 0;

    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb_aes_cfg_regs #(.ADDR_W(ADDR_W), .KEY_W(KEY_W), .SIZE_W(SIZE_W)) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hready(hready), .hwdata(hwdata), .hreadyout(hreadyout),
        .hresp(hresp), .hrdata(hrdata), .src_addr(src_addr), .dst_addr(dst_addr),
        .size_data(size_data), .mode(mode), .key(key), .start(start),
        .busy_in(busy_in), .done_in(done_in)
`ifdef AES_CFG_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic addr_phase(input logic [ADDR_W-1:0] a, input logic wr);
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    endtask

    task automatic ahb_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        addr_phase(a, 1'b1);
        @(posedge hclk); #1;
        bus_idle();
        hwdata = d;
        @(posedge hclk); #1;
    endtask

    task automatic ahb_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
        addr_phase(a, 1'b0);
        @(posedge hclk); #1;
        bus_idle();
        d = hrdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        tests++; if (hreadyout !== 1'b1) begin fails++; $display("FAIL reset_hreadyout got %b exp 1", hreadyout); end
        tests++; if (hresp !== 1'b0) begin fails++; $display("FAIL reset_hresp got %b exp 0", hresp); end
        tests++; if (hrdata !== 32'h0) begin fails++; $display("FAIL reset_hrdata got %h exp 0", hrdata); end
        tests++; if ({src_addr, dst_addr, size_data, mode, start} !== '0) begin
            fails++; $display("FAIL reset_regs got %h %h %h %b %b exp all 0", src_addr, dst_addr, size_data, mode, start);
        end
        tests++; if (key !== '0) begin fails++; $display("FAIL reset_key got %h exp 0", key); end
        ahb_read(12'h000, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_read_src got %h exp 00000000", d); end
    endtask

    task automatic test_back_to_back();
        addr_phase(12'h000, 1'b1);
        @(posedge hclk); #1;
        tests++; if (hrdata !== 32'h0) begin fails++; $display("FAIL b2b_hrdata_in_write got %h exp 0", hrdata); end
        hwdata = 32'hDEAD_BEEF;
        hsel = 1'b1; htrans = 2'b10; haddr = 12'h000; hwrite = 1'b0;
        @(posedge hclk); #1;
        bus_idle();
        tests++; if (hrdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL b2b_read got %h exp deadbeef", hrdata); end
        tests++; if (src_addr !== 32'hDEAD_BEEF) begin fails++; $display("FAIL b2b_src_addr got %h exp deadbeef", src_addr); end
        ahb_write(12'h004, 32'h1234_5678);
        tests++; if (dst_addr !== 32'h1234_5678) begin fails++; $display("FAIL dst_addr got %h exp 12345678", dst_addr); end
    endtask

    task automatic test_key();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) ahb_write(ADDR_W'(12'h020 + 4 * i), 32'(i));
        tests++; if (key[255:224] !== 32'h0) begin fails++; $display("FAIL key_msw got %h exp 0", key[255:224]); end
        tests++; if (key[63:32] !== 32'h6) begin fails++; $display("FAIL key_w6 got %h exp 6", key[63:32]); end
        tests++; if (key[31:0] !== 32'h7) begin fails++; $display("FAIL key_lsw got %h exp 7", key[31:0]); end
        ahb_read(12'h03C, d);
        tests++; if (d !== 32'h7) begin fails++; $display("FAIL key_read got %h exp 7", d); end
    endtask

    task automatic test_start();
        logic [31:0] d;
        ahb_write(12'h008, 32'h40);
        tests++; if (size_data !== 32'h40) begin fails++; $display("FAIL size got %h exp 40", size_data); end
        addr_phase(12'h00C, 1'b1);
        @(posedge hclk); #1;
        bus_idle();
        hwdata = 32'h5;
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL start_early got %b exp 0", start); end
        @(posedge hclk); #1;
        tests++; if (start !== 1'b1) begin fails++; $display("FAIL start_pulse got %b exp 1", start); end
        tests++; if (mode !== 2'b01) begin fails++; $display("FAIL start_mode got %b exp 01", mode); end
        @(posedge hclk); #1;
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL start_width got %b exp 0", start); end
        // Busy core: CTRL and SRC writes dropped, CFG_ERR raised.
        busy_in = 1'b1;
        ahb_write(12'h00C, 32'h6);
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL busy_start got %b exp 0", start); end
        tests++; if (mode !== 2'b01) begin fails++; $display("FAIL busy_mode got %b exp 01", mode); end
        ahb_write(12'h000, 32'h1111_2222);
        tests++; if (src_addr !== 32'hDEAD_BEEF) begin fails++; $display("FAIL busy_src got %h exp deadbeef", src_addr); end
        ahb_read(12'h010, d);
        tests++; if (d !== 32'h5) begin fails++; $display("FAIL busy_status got %h exp 5", d); end
        busy_in = 1'b0;
        ahb_write(12'h010, 32'h4);
        ahb_read(12'h010, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL w1c_cfg_err got %h exp 0", d); end
        // Zero size: no pulse, CFG_ERR.
        ahb_write(12'h008, 32'h0);
        ahb_write(12'h00C, 32'h4);
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL size0_start got %b exp 0", start); end
        ahb_read(12'h010, d);
        tests++; if (d !== 32'h4) begin fails++; $display("FAIL size0_status got %h exp 4", d); end
        ahb_write(12'h010, 32'h4);
    endtask

    task automatic test_error();
        addr_phase(12'h0FC, 1'b0);
        @(posedge hclk); #1;
        bus_idle();
        tests++; if ({hreadyout, hresp} !== 2'b01) begin fails++; $display("FAIL err1 got rdy=%b resp=%b exp rdy=0 resp=1", hreadyout, hresp); end
        @(posedge hclk); #1;
        tests++; if ({hreadyout, hresp} !== 2'b11) begin fails++; $display("FAIL err2 got rdy=%b resp=%b exp rdy=1 resp=1", hreadyout, hresp); end
        @(posedge hclk); #1;
        tests++; if ({hreadyout, hresp} !== 2'b10) begin fails++; $display("FAIL err_end got rdy=%b resp=%b exp rdy=1 resp=0", hreadyout, hresp); end
        ahb_write(12'h040, 32'hFFFF_FFFF);
        tests++; if (key[31:0] !== 32'h7 || src_addr !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL err_side_effect got key0=%h src=%h exp 7 deadbeef", key[31:0], src_addr);
        end
`ifndef AES_CFG_IRQ_EN
        addr_phase(12'h014, 1'b1);
        @(posedge hclk); #1;
        bus_idle();
        tests++; if ({hreadyout, hresp} !== 2'b01) begin fails++; $display("FAIL irqen_unmapped got rdy=%b resp=%b exp rdy=0 resp=1", hreadyout, hresp); end
        @(posedge hclk); #1;
`endif
    endtask

    task automatic test_done();
        logic [31:0] d;
`ifdef AES_CFG_IRQ_EN
        ahb_write(12'h014, 32'h2);
`endif
        addr_phase(12'h010, 1'b1);
        @(posedge hclk); #1;
        bus_idle();
        hwdata = 32'h2;
        done_in = 1'b1;
        @(posedge hclk); #1;
        done_in = 1'b0;
        ahb_read(12'h010, d);
        tests++; if (d !== 32'h2) begin fails++; $display("FAIL done_set_wins got %h exp 2", d); end
`ifdef AES_CFG_IRQ_EN
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set got %b exp 1", irq); end
`endif
        ahb_write(12'h010, 32'h2);
        ahb_read(12'h010, d);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL done_w1c got %h exp 0", d); end
`ifdef AES_CFG_IRQ_EN
        @(posedge hclk); #1;
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear got %b exp 0", irq); end
        ahb_read(12'h014, d);
        tests++; if (d !== 32'h2) begin fails++; $display("FAIL irqen_read got %h exp 2", d); end
`endif
    endtask

    task automatic test_reset_mid();
        ahb_write(12'h008, 32'h10);
        addr_phase(12'h00C, 1'b1);
        @(posedge hclk); #1;
        bus_idle();
        hwdata = 32'h5;
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL rstmid_start got %b exp 0", start); end
        tests++; if (hreadyout !== 1'b1) begin fails++; $display("FAIL rstmid_hreadyout got %b exp 1", hreadyout); end
        tests++; if (size_data !== 32'h0 || src_addr !== 32'h0 || mode !== 2'b00) begin
            fails++; $display("FAIL rstmid_regs got size=%h src=%h mode=%b exp 0", size_data, src_addr, mode);
        end
        @(posedge hclk); #1;
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL rstmid_late_start got %b exp 0", start); end
    endtask

    initial begin
        hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hwdata = '0; busy_in = 1'b0; done_in = 1'b0;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        test_reset();
        test_back_to_back();
        test_key();
        test_start();
        test_error();
        test_done();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
